// File: rtl/uc_prog_pkg.sv
// Shared types and constants for the microcontroller programming-port router.
package uc_prog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALLOC,
    ST_BURST,
    ST_BARRIER,
    ST_WAIT_RESP,
    ST_BCAST,
    ST_BCAST_RSP
  } state_e;

  localparam logic [3:0]  BARRIER_OFS = 4'h4;
  localparam logic [31:0] DEAD_ERR    = 32'hDEAD_0000;

  // Error word returned upstream when a barrier is aborted on channel idx.
  function automatic logic [31:0] dead_word(input logic [3:0] idx);
    return DEAD_ERR | {28'h0, idx};
  endfunction

endpackage

// File: rtl/uc_prog_multi_router_if.sv
// Upstream data port plus NB_CH programming channels; slave is the router's view.
interface uc_prog_multi_router_if #(
  parameter int unsigned NB_CH      = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
);
  logic                                  req_i;
  logic                                  wen_i;
  logic [ADDR_WIDTH-1:0]                 add_i;
  logic [BE_WIDTH-1:0]                   be_i;
  logic [DATA_WIDTH-1:0]                 wdata_i;
  logic                                  gnt_o;
  logic                                  r_valid_o;
  logic [DATA_WIDTH-1:0]                 r_rdata_o;
  logic [NB_CH-1:0]                      ch_req_o;
  logic [NB_CH-1:0]                      ch_wen_o;
  logic [NB_CH-1:0][ADDR_WIDTH-1:0]      ch_add_o;
  logic [NB_CH-1:0][DATA_WIDTH-1:0]      ch_wdata_o;
  logic [NB_CH-1:0][BE_WIDTH-1:0]        ch_be_o;
  logic [NB_CH-1:0]                      ch_gnt_i;
  logic [NB_CH-1:0]                      ch_r_valid_i;
  logic [NB_CH-1:0][DATA_WIDTH-1:0]      ch_r_rdata_i;
  logic                                  timeout_o;

  modport slave (
    input  req_i, wen_i, add_i, be_i, wdata_i, ch_gnt_i, ch_r_valid_i, ch_r_rdata_i,
    output gnt_o, r_valid_o, r_rdata_o, ch_req_o, ch_wen_o, ch_add_o, ch_wdata_o,
           ch_be_o, timeout_o
  );

  modport master (
    output req_i, wen_i, add_i, be_i, wdata_i, ch_gnt_i, ch_r_valid_i, ch_r_rdata_i,
    input  gnt_o, r_valid_o, r_rdata_o, ch_req_o, ch_wen_o, ch_add_o, ch_wdata_o,
           ch_be_o, timeout_o
  );
endinterface

// File: rtl/uc_prog_rsp_mux.sv
// Lowest-index-wins response mux across the programming channels.
module uc_prog_rsp_mux #(
  parameter int unsigned NB_CH      = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [NB_CH-1:0]                 valid_i,
  input  logic [NB_CH-1:0][DATA_WIDTH-1:0] data_i,
  output logic                             valid_o,
  output logic [DATA_WIDTH-1:0]            data_o
);

  always_comb begin
    valid_o = 1'b0;
    data_o  = '0;
    for (int unsigned k = 0; k < NB_CH; k++) begin
      if (valid_i[k] && !valid_o) begin
        valid_o = 1'b1;
        data_o  = data_i[k];
      end
    end
  end

endmodule

// File: rtl/uc_prog_multi_router.sv
// Routes one microcontroller data port onto NB_CH engine programming channels.
// Optional barrier watchdog: define UC_PROG_TIMEOUT_EN.
module uc_prog_multi_router
  import uc_prog_pkg::*;
#(
  parameter int unsigned NB_CH       = 2,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned BE_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned BURST_LEN   = 8,
  parameter logic [3:0]  CH_ID_BASE  = 4'h6,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  uc_prog_multi_router_if.slave bus
);

  localparam int unsigned SelW     = $clog2(NB_CH);
  localparam logic [4:0]  NbCh5    = 5'(NB_CH);
  localparam logic [3:0]  BurstLen = 4'(BURST_LEN);

  state_e                 state_q, state_d;
  logic [SelW-1:0]        sel_q, sel_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [NB_CH-1:0]       gmask_q, gmask_d, rmask_q, rmask_d;
  logic [DATA_WIDTH-1:0]  rdata0_q, rdata0_d;

  logic [3:0]             idx, ch_id;
  logic                   idx_ok, id_ok, be_full;
  logic [NB_CH-1:0]       sel_oh, fwd_mask;
  logic                   fwd_clr, gnt_hit, rv_hit, g_full, r_full;
  logic                   mux_valid;
  logic [DATA_WIDTH-1:0]  mux_data;
  logic [ADDR_WIDTH-1:0]  add_clr;

  logic [NB_CH-1:0]                 ch_req, ch_wen;
  logic [NB_CH-1:0][ADDR_WIDTH-1:0] ch_add;
  logic [NB_CH-1:0][DATA_WIDTH-1:0] ch_wd;
  logic [NB_CH-1:0][BE_WIDTH-1:0]   ch_be;

  assign idx     = bus.add_i[7:4];
  assign ch_id   = bus.wdata_i[19:16] - CH_ID_BASE;
  assign idx_ok  = {1'b0, idx} < NbCh5;
  assign id_ok   = {1'b0, ch_id} < NbCh5;
  assign be_full = bus.be_i == '1;
  assign sel_oh  = NB_CH'(1) << sel_q;
  assign gnt_hit = |(bus.ch_gnt_i & sel_oh);
  assign rv_hit  = |(bus.ch_r_valid_i & sel_oh);
  assign g_full  = &(gmask_q | bus.ch_gnt_i);
  assign r_full  = &(rmask_q | bus.ch_r_valid_i);

  uc_prog_rsp_mux #(
    .NB_CH      (NB_CH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_mux (
    .valid_i (bus.ch_r_valid_i),
    .data_i  (bus.ch_r_rdata_i),
    .valid_o (mux_valid),
    .data_o  (mux_data)
  );

`ifdef UC_PROG_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            tmo_fire;

  // A response landing on the abort cycle wins over the watchdog.
  assign tmo_fire = (state_q == ST_BARRIER || (state_q == ST_WAIT_RESP && !rv_hit)) &&
                    tmo_q == TmoW'(TIMEOUT_CYC - 1);
  assign bus.timeout_o = tmo_fire;
`else
  assign bus.timeout_o = 1'b0;
  // The watchdog limit only matters when the watchdog is built in.
  if (TIMEOUT_CYC == 0) begin : g_tmo_unused
  end
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    gmask_d  = gmask_q;
    rmask_d  = rmask_q;
    rdata0_d = rdata0_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_i) begin
          if (bus.wen_i && idx_ok) begin
            sel_d   = idx[SelW-1:0];
            state_d = (bus.add_i[3:0] == BARRIER_OFS) ? ST_BARRIER : ST_ALLOC;
          end else if (!bus.wen_i && be_full && id_ok) begin
            sel_d   = ch_id[SelW-1:0];
            state_d = ST_BURST;
          end else begin
            state_d = ST_BCAST;
          end
        end
      end
      ST_ALLOC:     if (!bus.req_i) state_d = ST_IDLE;
      ST_BURST: begin
        if (gnt_hit && cnt_q != BurstLen) cnt_d = cnt_q + 4'd1;
        if (!bus.req_i && cnt_q == BurstLen) state_d = ST_IDLE;
      end
      ST_BARRIER:   if (gnt_hit) state_d = ST_WAIT_RESP;
      ST_WAIT_RESP: if (rv_hit) state_d = ST_IDLE;
      ST_BCAST: begin
        gmask_d = gmask_q | bus.ch_gnt_i;
        if (g_full) state_d = ST_BCAST_RSP;
      end
      ST_BCAST_RSP: begin
        rmask_d = rmask_q | bus.ch_r_valid_i;
        if (bus.ch_r_valid_i[0] && !rmask_q[0]) rdata0_d = bus.ch_r_rdata_i[0];
        if (r_full) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef UC_PROG_TIMEOUT_EN
    tmo_d = (state_q == ST_BARRIER || state_q == ST_WAIT_RESP) ? tmo_q + TmoW'(1) : '0;
    if (tmo_fire) state_d = ST_IDLE;
`endif
    if (state_q == ST_IDLE || state_d != state_q) begin
      cnt_d   = '0;
      gmask_d = '0;
      rmask_d = '0;
`ifdef UC_PROG_TIMEOUT_EN
      tmo_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      gmask_q  <= '0;
      rmask_q  <= '0;
      rdata0_q <= '0;
`ifdef UC_PROG_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      gmask_q  <= gmask_d;
      rmask_q  <= rmask_d;
      rdata0_q <= rdata0_d;
`ifdef UC_PROG_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  always_comb begin
    fwd_mask = '0;
    fwd_clr  = 1'b0;
    unique case (state_q)
      ST_ALLOC, ST_BARRIER, ST_WAIT_RESP: begin
        fwd_mask = sel_oh;
        fwd_clr  = 1'b1;
      end
      ST_BURST: fwd_mask = sel_oh;
      ST_BCAST: fwd_mask = ~gmask_q;
      default:  fwd_mask = '0;
    endcase
  end

  always_comb begin
    add_clr      = bus.add_i;
    add_clr[7:4] = '0;
    ch_req = '0;
    ch_wen = '1;
    ch_add = '0;
    ch_wd  = '0;
    ch_be  = '0;
    for (int unsigned k = 0; k < NB_CH; k++) begin
      if (fwd_mask[k]) begin
        ch_req[k] = bus.req_i;
        ch_wen[k] = bus.wen_i;
        ch_add[k] = fwd_clr ? add_clr : bus.add_i;
        ch_wd[k]  = bus.wdata_i;
        ch_be[k]  = bus.be_i;
      end
    end
  end

  assign bus.ch_req_o   = ch_req;
  assign bus.ch_wen_o   = ch_wen;
  assign bus.ch_add_o   = ch_add;
  assign bus.ch_wdata_o = ch_wd;
  assign bus.ch_be_o    = ch_be;

  // Broadcast hides per-channel handshakes until every channel has completed.
  always_comb begin
    bus.gnt_o     = |bus.ch_gnt_i;
    bus.r_valid_o = mux_valid;
    bus.r_rdata_o = mux_data;
    if (state_q == ST_BCAST) begin
      bus.gnt_o     = g_full;
      bus.r_valid_o = 1'b0;
      bus.r_rdata_o = '0;
    end else if (state_q == ST_BCAST_RSP) begin
      bus.gnt_o     = 1'b0;
      bus.r_valid_o = r_full;
      bus.r_rdata_o = '0;
      if (r_full) begin
        bus.r_rdata_o = (bus.ch_r_valid_i[0] && !rmask_q[0]) ? bus.ch_r_rdata_i[0] : rdata0_q;
      end
    end
`ifdef UC_PROG_TIMEOUT_EN
    if (tmo_fire) begin
      bus.r_valid_o = 1'b1;
      bus.r_rdata_o = DATA_WIDTH'(dead_word(4'(sel_q)));
    end
`endif
  end

endmodule

// File: tb/tb_uc_prog_multi_router.sv
// Directed and randomized transactions on a 2-channel router, checked against a transaction-level model.
module tb_uc_prog_multi_router;

  localparam int unsigned NB    = 2;
  localparam int unsigned BLEN  = 8;
  localparam logic [3:0]  IDB   = 4'h6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  uc_prog_multi_router_if #(.NB_CH(NB), .DATA_WIDTH(32), .ADDR_WIDTH(32), .BE_WIDTH(4)) bus ();

  uc_prog_multi_router #(
    .NB_CH(NB), .DATA_WIDTH(32), .ADDR_WIDTH(32), .BE_WIDTH(4),
    .BURST_LEN(BLEN), .CH_ID_BASE(IDB), .TIMEOUT_CYC(1024)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic cmp(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Channels in fwd carry the upstream request (index nibble cleared when clr); the rest idle.
  task automatic check(input string tag, input logic [NB-1:0] fwd, input bit clr,
                       input bit eg, input bit ev, input logic [31:0] ed);
    logic [NB-1:0]       er, ew;
    logic [NB-1:0][31:0] ea, edd;
    logic [NB-1:0][3:0]  eb;
    logic [31:0]         a;
    #3;
    for (int k = 0; k < NB; k++) begin
      a = bus.add_i;
      if (clr) a[7:4] = 4'h0;
      er[k]  = fwd[k] ? bus.req_i   : 1'b0;
      ew[k]  = fwd[k] ? bus.wen_i   : 1'b1;
      ea[k]  = fwd[k] ? a           : 32'h0;
      edd[k] = fwd[k] ? bus.wdata_i : 32'h0;
      eb[k]  = fwd[k] ? bus.be_i    : 4'h0;
    end
    cmp({tag, ".ch_req"},   bus.ch_req_o,   er);
    cmp({tag, ".ch_wen"},   bus.ch_wen_o,   ew);
    cmp({tag, ".ch_add"},   bus.ch_add_o,   ea);
    cmp({tag, ".ch_wdata"}, bus.ch_wdata_o, edd);
    cmp({tag, ".ch_be"},    bus.ch_be_o,    eb);
    cmp({tag, ".gnt"},      bus.gnt_o,      eg);
    cmp({tag, ".r_valid"},  bus.r_valid_o,  ev);
    cmp({tag, ".r_rdata"},  bus.r_rdata_o,  ed);
    cmp({tag, ".timeout"},  bus.timeout_o,  1'b0);
  endtask

  task automatic up(input logic r, input logic w, input logic [31:0] a,
                    input logic [3:0] b, input logic [31:0] d);
    bus.req_i = r; bus.wen_i = w; bus.add_i = a; bus.be_i = b; bus.wdata_i = d;
    bus.ch_gnt_i = '0; bus.ch_r_valid_i = '0; bus.ch_r_rdata_i = '0;
  endtask

  task automatic do_alloc(input logic [31:0] a, input int gdly, input logic [31:0] rd, input bit both);
    int idx = int'(a[7:4]);
    logic [NB-1:0] m = NB'(1) << idx;
    logic [31:0] exp;
    cyc(); up(1'b1, 1'b1, a, 4'($urandom), $urandom);
    check("alloc_dec", '0, 0, 0, 0, 32'h0);
    for (int t = 0; t <= gdly; t++) begin
      cyc(); bus.ch_gnt_i = (t == gdly) ? m : '0;
      check("alloc_fwd", m, 1, t == gdly, 0, 32'h0);
    end
    cyc(); bus.ch_gnt_i = '0; bus.req_i = 1'b0;
    for (int k = 0; k < NB; k++) bus.ch_r_rdata_i[k] = $urandom;
    bus.ch_r_rdata_i[idx] = rd;
    bus.ch_r_valid_i = both ? '1 : m;
    exp = both ? bus.ch_r_rdata_i[0] : rd;
    check("alloc_rsp", m, 1, 0, 1, exp);
    cyc(); bus.ch_r_valid_i = '0;
    check("alloc_idle", '0, 0, 0, 0, 32'h0);
  endtask

  task automatic do_barrier(input int idx, input int gdly, input int wdly, input logic [31:0] rd);
    logic [NB-1:0] m = NB'(1) << idx;
    logic [31:0] a = $urandom;
    logic [31:0] od;
    a[7:0] = {4'(idx), 4'h4};
    cyc(); up(1'b1, 1'b1, a, 4'hF, $urandom);
    check("bar_dec", '0, 0, 0, 0, 32'h0);
    for (int t = 0; t <= gdly; t++) begin
      cyc(); bus.ch_gnt_i = (t == gdly) ? m : '0;
      check("bar_fwd", m, 1, t == gdly, 0, 32'h0);
    end
    for (int t = 0; t <= wdly; t++) begin
      cyc(); bus.ch_gnt_i = '0; bus.req_i = 1'b0; bus.ch_r_valid_i = '0;
      if (t == wdly) begin
        bus.ch_r_valid_i = m; bus.ch_r_rdata_i[idx] = rd;
        check("bar_rsp", m, 1, 0, 1, rd);
      end else if ($urandom_range(0, 3) == 0) begin
        od = $urandom;
        bus.ch_r_valid_i = ~m; bus.ch_r_rdata_i[1 - idx] = od;
        check("bar_other", m, 1, 0, 1, od);
      end else begin
        check("bar_wait", m, 1, 0, 0, 32'h0);
      end
    end
    cyc(); bus.ch_r_valid_i = '0;
    check("bar_idle", '0, 0, 0, 0, 32'h0);
  endtask

  task automatic burst_start(input int ch);
    logic [31:0] d = $urandom;
    d[19:16] = IDB + 4'(ch);
    cyc(); up(1'b1, 1'b0, $urandom, 4'hF, d);
    check("burst_dec", '0, 0, 0, 0, 32'h0);
  endtask

  // probe >= 0 drops req for one cycle after that many grants; the burst must not end early.
  task automatic burst_body(input int ch, input int probe, input int extra);
    logic [NB-1:0] m = NB'(1) << ch;
    int got = 0;
    bit dropped = 0;
    bit g;
    for (int it = 0; it < 400 && got < BLEN; it++) begin
      cyc();
      if (probe >= 0 && got == probe && !dropped) begin
        bus.req_i = 1'b0; bus.ch_gnt_i = '0; dropped = 1;
        check("burst_probe", m, 0, 0, 0, 32'h0);
      end else begin
        bus.req_i = 1'b1; g = ($urandom % 3) != 0; bus.ch_gnt_i = g ? m : '0;
        check("burst_fwd", m, 0, g, 0, 32'h0);
        if (g) got++;
      end
    end
    for (int e = 0; e < extra; e++) begin
      cyc(); bus.req_i = 1'b1; bus.ch_gnt_i = m;
      check("burst_sat", m, 0, 1, 0, 32'h0);
    end
    cyc(); bus.req_i = 1'b0; bus.ch_gnt_i = '0;
    check("burst_end", m, 0, 0, 0, 32'h0);
    cyc();
    check("burst_idle", '0, 0, 0, 0, 32'h0);
  endtask

  task automatic do_bcast(input int kind, input int g0, input int g1, input int r0, input int r1);
    int g[NB], r[NB];
    int gmax, rmax;
    logic [31:0] a = $urandom, d = $urandom, d0 = 32'h0;
    logic [3:0]  b = 4'hF;
    logic        w = 1'b0;
    logic [NB-1:0] fm;
    g[0] = g0; g[1] = g1; r[0] = r0; r[1] = r1;
    gmax = (g0 > g1) ? g0 : g1;
    rmax = (r0 > r1) ? r0 : r1;
    case (kind)
      0:       b = 4'($urandom_range(0, 14));
      1:       d[19:16] = IDB + 4'(NB) + 4'($urandom_range(0, 13));
      default: begin w = 1'b1; a[7:4] = 4'($urandom_range(NB, 15)); end
    endcase
    cyc(); up(1'b1, w, a, b, d);
    check("bc_dec", '0, 0, 0, 0, 32'h0);
    for (int t = 0; t <= gmax; t++) begin
      cyc();
      for (int k = 0; k < NB; k++) begin
        bus.ch_gnt_i[k] = (t == g[k]);
        fm[k] = (t <= g[k]);
      end
      check("bc_gnt", fm, 0, t == gmax, 0, 32'h0);
    end
    for (int t = 0; t <= rmax; t++) begin
      cyc(); bus.req_i = 1'b0; bus.ch_gnt_i = '0;
      for (int k = 0; k < NB; k++) begin
        bus.ch_r_valid_i[k] = (t == r[k]);
        bus.ch_r_rdata_i[k] = $urandom;
        if (k == 0 && t == r[0]) d0 = bus.ch_r_rdata_i[0];
      end
      check("bc_rsp", '0, 0, 0, t == rmax, (t == rmax) ? d0 : 32'h0);
    end
    cyc(); bus.ch_r_valid_i = '0;
    check("bc_idle", '0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] a;
    int ch;
    up(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst_n = 1'b0;
    cyc(); cyc();
    check("reset", '0, 0, 0, 0, 32'h0);
    rst_n = 1'b1;

    do_alloc(32'h0000_0010, 0, 32'h0000_1234, 0);
    burst_start(1); burst_body(1, -1, 0);
    do_barrier(0, 1, 20, 32'hCAFE_0001);
    do_bcast(0, 2, 5, 1, 3);

    // Reset in the middle of a burst, after three grants.
    burst_start(1);
    for (int i = 0; i < 3; i++) begin
      cyc(); bus.ch_gnt_i = 2'b10;
      check("rb_fwd", 2'b10, 0, 1, 0, 32'h0);
    end
    cyc(); rst_n = 1'b0; bus.req_i = 1'b0; bus.ch_gnt_i = '0;
    check("rb_rstcyc", 2'b10, 0, 0, 0, 32'h0);
    cyc(); rst_n = 1'b1;
    check("rb_after", '0, 0, 0, 0, 32'h0);
    burst_start(1); burst_body(1, 5, 1);

    for (int n = 0; n < 40; n++) begin
      ch = $urandom_range(0, NB - 1);
      case ($urandom_range(0, 3))
        0: begin
          a = $urandom; a[7:4] = 4'(ch);
          if (a[3:0] == 4'h4) a[3:0] = 4'h5;
          do_alloc(a, $urandom_range(0, 2), $urandom, $urandom_range(0, 1) == 1);
        end
        1: begin burst_start(ch); burst_body(ch, $urandom_range(0, 1) == 1 ? $urandom_range(0, BLEN - 1) : -1, $urandom_range(0, 2)); end
        2: do_barrier(ch, $urandom_range(0, 2), $urandom_range(0, 25), $urandom);
        default: do_bcast($urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(0, 4),
                          $urandom_range(0, 4), $urandom_range(0, 4));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
